// File: rtl/multicycle_controller.sv
// multicycle_controller: five-state multicycle CPU control FSM
// (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK) for R, I, LW and SW classes.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   Opcode[6:0]           instruction opcode, sampled in DECODE
//   I_Ready, D_Ready      instruction / data memory ready handshakes
//   I_Req                 instruction fetch request
//   IR_Write, PC_Write    IR load / PC+4 load, pulse on the completing fetch cycle
//   ALU_Op[1:0], ALU_Src  ALU class and operand select
//   Mem_Read, Mem_Write   data memory requests
//   Mem_to_Reg, Reg_Write write-back controls
//   Retire, Illegal_Op    completion / unsupported-opcode pulses
//   State[2:0]            current FSM state
//   Instret[31:0]         retired-instruction count
//
// Build option: define INSTRET_COUNT_EN to implement the Instret counter;
// otherwise Instret is tied to zero.
//
// Outputs that depend only on the state are registered from the next state.
// Outputs that must react to a same-cycle handshake (I_Req after reset
// release, IR_Write/PC_Write, Retire on SW, Illegal_Op) are decoded from
// the state register combinationally.
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  Opcode,
  input  logic        I_Ready,
  input  logic        D_Ready,
  output logic        I_Req,
  output logic        IR_Write,
  output logic        PC_Write,
  output logic [1:0]  ALU_Op,
  output logic        ALU_Src,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic        Mem_to_Reg,
  output logic        Reg_Write,
  output logic        Retire,
  output logic        Illegal_Op,
  output logic [2:0]  State,
  output logic [31:0] Instret
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_R   = 3'd0,
    C_I   = 3'd1,
    C_LW  = 3'd2,
    C_SW  = 3'd3,
    C_ILL = 3'd4
  } cls_t;

  state_t     state_q, nxt_state;
  cls_t       cls_q, nxt_cls, dec_cls;
  logic [1:0] alu_op_d;
  logic       alu_src_d;

  // Opcode classification
  always_comb begin
    dec_cls = C_ILL;
    case (Opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LW;
      7'b0100011: dec_cls = C_SW;
      default:    dec_cls = C_ILL;
    endcase
  end

  // Next state; class is captured only in DECODE so later Opcode changes are ignored
  always_comb begin
    nxt_state = S_FETCH;
    nxt_cls   = cls_q;
    case (state_q)
      S_FETCH:     nxt_state = I_Ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        nxt_cls   = dec_cls;
        nxt_state = (dec_cls == C_ILL) ? S_FETCH : S_EXECUTE;
      end
      S_EXECUTE:   nxt_state = (cls_q == C_LW || cls_q == C_SW) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        if (!D_Ready)            nxt_state = S_MEMORY;
        else if (cls_q == C_LW)  nxt_state = S_WRITEBACK;
        else                     nxt_state = S_FETCH;
      end
      S_WRITEBACK: nxt_state = S_FETCH;
      default:     nxt_state = S_FETCH;  // unreachable encodings recover
    endcase
  end

  // ALU controls for the state being entered; zero in FETCH/DECODE
  always_comb begin
    alu_op_d  = 2'b00;
    alu_src_d = 1'b0;
    if (nxt_state == S_EXECUTE || nxt_state == S_MEMORY || nxt_state == S_WRITEBACK) begin
      case (nxt_cls)
        C_R:        begin alu_op_d = 2'b10; alu_src_d = 1'b0; end
        C_I:        begin alu_op_d = 2'b00; alu_src_d = 1'b1; end
        C_LW, C_SW: begin alu_op_d = 2'b01; alu_src_d = 1'b1; end
        default:    begin alu_op_d = 2'b00; alu_src_d = 1'b0; end
      endcase
    end
  end

  // State, class and state-derived registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      cls_q      <= C_ILL;
      ALU_Op     <= 2'b00;
      ALU_Src    <= 1'b0;
      Mem_Read   <= 1'b0;
      Mem_Write  <= 1'b0;
      Mem_to_Reg <= 1'b0;
      Reg_Write  <= 1'b0;
    end else begin
      state_q    <= nxt_state;
      cls_q      <= nxt_cls;
      ALU_Op     <= alu_op_d;
      ALU_Src    <= alu_src_d;
      Mem_Read   <= (nxt_state == S_MEMORY)    && (nxt_cls == C_LW);
      Mem_Write  <= (nxt_state == S_MEMORY)    && (nxt_cls == C_SW);
      Mem_to_Reg <= (nxt_state == S_WRITEBACK) && (nxt_cls == C_LW);
      Reg_Write  <= (nxt_state == S_WRITEBACK);
    end
  end

  // I_Req gated by reset so it is low during reset and high the first cycle after
  assign I_Req      = (state_q == S_FETCH) && !reset;
  assign IR_Write   = I_Req && I_Ready;
  assign PC_Write   = I_Req && I_Ready;
  assign Illegal_Op = (state_q == S_DECODE) && (dec_cls == C_ILL);
  assign Retire     = (state_q == S_WRITEBACK) ||
                      ((state_q == S_MEMORY) && (cls_q == C_SW) && D_Ready);
  assign State      = state_q;

`ifdef INSTRET_COUNT_EN
  logic [CNT_W-1:0] instret_q;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instret_q <= '0;
    else if (Retire) instret_q <= instret_q + CNT_W'(1);
  end

  assign Instret = instret_q;
`else
  assign Instret = CNT_W'(0);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the stimulus process pushes the
// hand-computed expected output vector for every cycle it drives, and a
// monitor on the falling edge pops and compares it against the DUT.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  Opcode = 7'd0;
  logic        I_Ready = 1'b1;
  logic        D_Ready = 1'b1;
  logic        I_Req, IR_Write, PC_Write, ALU_Src, Mem_Read, Mem_Write;
  logic        Mem_to_Reg, Reg_Write, Retire, Illegal_Op;
  logic [1:0]  ALU_Op;
  logic [2:0]  State;
  logic [31:0] Instret;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic [14:0] sig;
    logic [31:0] cnt;
    logic [7:0]  tag;
  } exp_t;

  exp_t        q[$];
  logic [31:0] exp_cnt = 32'd0;
  int          n_total = 0;
  int          n_pass  = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .I_Ready(I_Ready), .D_Ready(D_Ready),
    .I_Req(I_Req), .IR_Write(IR_Write), .PC_Write(PC_Write), .ALU_Op(ALU_Op),
    .ALU_Src(ALU_Src), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Mem_to_Reg(Mem_to_Reg), .Reg_Write(Reg_Write), .Retire(Retire),
    .Illegal_Op(Illegal_Op), .State(State), .Instret(Instret)
  );

  always #5 clk = ~clk;

  // Expected vector: {State, I_Req, IR_Write, PC_Write, ALU_Op, ALU_Src,
  //                   Mem_Read, Mem_Write, Mem_to_Reg, Reg_Write, Retire, Illegal_Op}
  function automatic logic [14:0] ev(input logic [2:0] st, input logic ireq, input logic irw,
                                     input logic pcw, input logic [1:0] aop, input logic asrc,
                                     input logic mr, input logic mw, input logic m2r,
                                     input logic rw, input logic ret, input logic ill);
    return {st, ireq, irw, pcw, aop, asrc, mr, mw, m2r, rw, ret, ill};
  endfunction

  // Drive one cycle of inputs and queue the expected outputs for that cycle
  task automatic step(input logic r, input logic [6:0] op, input logic ir, input logic dr,
                      input logic [14:0] e, input logic [7:0] tag);
    exp_t x;
    @(posedge clk);
    #1;
    reset = r; Opcode = op; I_Ready = ir; D_Ready = dr;
    if (r) exp_cnt = 32'd0;
    x.sig = e; x.cnt = exp_cnt; x.tag = tag;
    q.push_back(x);
`ifdef INSTRET_COUNT_EN
    if (e[1]) exp_cnt = exp_cnt + 32'd1;
`endif
  endtask

  // Monitor: one comparison of the control vector and one of Instret per cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      logic [14:0] got;
      x = q.pop_front();
      got = {State, I_Req, IR_Write, PC_Write, ALU_Op, ALU_Src, Mem_Read, Mem_Write,
             Mem_to_Reg, Reg_Write, Retire, Illegal_Op};
      n_total++;
      if (got === x.sig) n_pass++;
      else $display("FAIL ctrl tag=%0d got=%b want=%b", x.tag, got, x.sig);
      n_total++;
      if (Instret === x.cnt) n_pass++;
      else $display("FAIL instret tag=%0d got=%h want=%h", x.tag, Instret, x.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: everything low, State=FETCH
    step(1, OP_R, 1, 1, ev(0,0,0,0,2'b00,0,0,0,0,0,0,0), 8'd1);
    step(1, OP_R, 1, 1, ev(0,0,0,0,2'b00,0,0,0,0,0,0,0), 8'd2);

    // R-type, ready high: 0,1,2,4 then back to FETCH
    step(0, OP_R, 1, 1, ev(0,1,1,1,2'b00,0,0,0,0,0,0,0), 8'd10);
    step(0, OP_R, 1, 1, ev(1,0,0,0,2'b00,0,0,0,0,0,0,0), 8'd11);
    step(0, OP_R, 1, 1, ev(2,0,0,0,2'b10,0,0,0,0,0,0,0), 8'd12);
    step(0, OP_R, 1, 1, ev(4,0,0,0,2'b10,0,0,0,0,1,1,0), 8'd13);

    // LW with D_Ready low for 3 MEMORY cycles: 8 cycles total
    step(0, OP_LW, 1, 1, ev(0,1,1,1,2'b00,0,0,0,0,0,0,0), 8'd20);
    step(0, OP_LW, 1, 1, ev(1,0,0,0,2'b00,0,0,0,0,0,0,0), 8'd21);
    step(0, OP_LW, 1, 1, ev(2,0,0,0,2'b01,1,0,0,0,0,0,0), 8'd22);
    step(0, OP_LW, 1, 0, ev(3,0,0,0,2'b01,1,1,0,0,0,0,0), 8'd23);
    step(0, OP_LW, 1, 0, ev(3,0,0,0,2'b01,1,1,0,0,0,0,0), 8'd24);
    step(0, OP_LW, 1, 0, ev(3,0,0,0,2'b01,1,1,0,0,0,0,0), 8'd25);
    step(0, OP_LW, 1, 1, ev(3,0,0,0,2'b01,1,1,0,0,0,0,0), 8'd26);
    step(0, OP_LW, 1, 1, ev(4,0,0,0,2'b01,1,0,0,1,1,1,0), 8'd27);

    // SW with I_Ready low for 2 cycles; Opcode scrambled after DECODE
    step(0, OP_SW,  0, 1, ev(0,1,0,0,2'b00,0,0,0,0,0,0,0), 8'd30);
    step(0, OP_SW,  0, 1, ev(0,1,0,0,2'b00,0,0,0,0,0,0,0), 8'd31);
    step(0, OP_SW,  1, 1, ev(0,1,1,1,2'b00,0,0,0,0,0,0,0), 8'd32);
    step(0, OP_SW,  1, 1, ev(1,0,0,0,2'b00,0,0,0,0,0,0,0), 8'd33);
    step(0, OP_BAD, 1, 1, ev(2,0,0,0,2'b01,1,0,0,0,0,0,0), 8'd34);
    step(0, OP_R,   1, 1, ev(3,0,0,0,2'b01,1,0,1,0,0,1,0), 8'd35);

    // Illegal opcode: pulse in DECODE, straight back to FETCH
    step(0, OP_BAD, 1, 1, ev(0,1,1,1,2'b00,0,0,0,0,0,0,0), 8'd40);
    step(0, OP_BAD, 1, 1, ev(1,0,0,0,2'b00,0,0,0,0,0,0,1), 8'd41);

    // I-type, with the ready inputs low where they are not consulted
    step(0, OP_I, 1, 0, ev(0,1,1,1,2'b00,0,0,0,0,0,0,0), 8'd50);
    step(0, OP_I, 0, 0, ev(1,0,0,0,2'b00,0,0,0,0,0,0,0), 8'd51);
    step(0, OP_I, 0, 0, ev(2,0,0,0,2'b00,1,0,0,0,0,0,0), 8'd52);
    step(0, OP_I, 0, 0, ev(4,0,0,0,2'b00,1,0,0,0,1,1,0), 8'd53);

    // Reset during SW MEMORY: Mem_Write drops at once, fetch restarts
    step(0, OP_SW, 1, 1, ev(0,1,1,1,2'b00,0,0,0,0,0,0,0), 8'd60);
    step(0, OP_SW, 1, 1, ev(1,0,0,0,2'b00,0,0,0,0,0,0,0), 8'd61);
    step(0, OP_SW, 1, 0, ev(2,0,0,0,2'b01,1,0,0,0,0,0,0), 8'd62);
    step(0, OP_SW, 1, 0, ev(3,0,0,0,2'b01,1,0,1,0,0,0,0), 8'd63);
    step(1, OP_SW, 1, 1, ev(0,0,0,0,2'b00,0,0,0,0,0,0,0), 8'd64);
    step(0, OP_R,  1, 1, ev(0,1,1,1,2'b00,0,0,0,0,0,0,0), 8'd65);
    step(0, OP_R,  1, 1, ev(1,0,0,0,2'b00,0,0,0,0,0,0,0), 8'd66);
    step(0, OP_R,  1, 1, ev(2,0,0,0,2'b10,0,0,0,0,0,0,0), 8'd67);
    step(0, OP_R,  1, 1, ev(4,0,0,0,2'b10,0,0,0,0,1,1,0), 8'd68);

    // Counter wrap: preload all-ones during FETCH, retire one R-type
    step(0, OP_R, 1, 1, ev(0,1,1,1,2'b00,0,0,0,0,0,0,0), 8'd70);
`ifdef INSTRET_COUNT_EN
    @(negedge clk);
    #1;
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    exp_cnt = 32'hFFFF_FFFF;
`endif
    step(0, OP_R, 1, 1, ev(1,0,0,0,2'b00,0,0,0,0,0,0,0), 8'd71);
    step(0, OP_R, 1, 1, ev(2,0,0,0,2'b10,0,0,0,0,0,0,0), 8'd72);
    step(0, OP_R, 1, 1, ev(4,0,0,0,2'b10,0,0,0,0,1,1,0), 8'd73);
    step(0, OP_R, 0, 1, ev(0,1,0,0,2'b00,0,0,0,0,0,0,0), 8'd74);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 Opcode  input  7  opcode field of the instruction register; valid from DECODE until the next FETCH.
REQ-004 I_Ready  input  1  instruction memory ready; fetch completes in a cycle with I_Req=1 and I_Ready=1.
REQ-005 D_Ready  input  1  data memory ready; access completes in a cycle with (Mem_Read|Mem_Write)=1 and D_Ready=1.
REQ-006 I_Req  output  1  instruction fetch request.
REQ-007 IR_Write  output  1  load instruction register; one-cycle pulse.
REQ-008 PC_Write  output  1  load PC+4; one-cycle pulse.
REQ-009 ALU_Op  output  2  ALU class: 10 R-type, 00 I-type ALU, 01 load/store address.
REQ-010 ALU_Src  output  1  0 = register operand, 1 = immediate.
REQ-011 Mem_Read  output  1  data memory read request.
REQ-012 Mem_Write  output  1  data memory write request.
REQ-013 Mem_to_Reg  output  1  write-back selects memory data.
REQ-014 Reg_Write  output  1  register file write enable; one-cycle pulse.
REQ-015 Retire  output  1  one-cycle pulse when an instruction completes.
REQ-016 Illegal_Op  output  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-017 State  output  3  current state: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4.
REQ-018 Instret  output  32  retired-instruction count (see Configuration).

Function
REQ-019 FSM states: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK; encodings 5-7 unreachable and, if ever entered, go to FETCH on the next edge.
REQ-020 FETCH: I_Req=1; hold while I_Ready=0; when I_Ready=1, IR_Write=1 and PC_Write=1 in that cycle, next state DECODE.
REQ-021 DECODE: Opcode classified and registered (0110011 R, 0010011 I, 0000011 LW, 0100011 SW); legal -> EXECUTE; any other opcode -> Illegal_Op=1 for that cycle, next state FETCH, no register or memory write.
REQ-022 EXECUTE: one cycle; R and I -> WRITEBACK; LW and SW -> MEMORY.
REQ-023 ALU_Op/ALU_Src held constant from EXECUTE through the last cycle of the instruction: R 10/0, I 00/1, LW and SW 01/1; 00/0 in FETCH and DECODE.
REQ-024 MEMORY: Mem_Read=1 (LW) or Mem_Write=1 (SW), held steady while D_Ready=0; on D_Ready=1, LW -> WRITEBACK, SW -> FETCH with Retire=1.
REQ-025 WRITEBACK: Reg_Write=1 for exactly one cycle; Mem_to_Reg=1 only for LW; Retire=1; next state FETCH.
REQ-026 Minimum latency with ready inputs tied high: R/I 4 cycles, SW 4 cycles, LW 5 cycles.
REQ-027 Mem_Read and Mem_Write are never both 1; Reg_Write and Mem_Write are never both 1.
REQ-028 Changes on Opcode outside DECODE have no effect on state or outputs.
REQ-029 Ready inputs asserted outside their request states are ignored.

Reset
REQ-030 While reset=1, every output is 0 (State=0, Instret=0) and the FSM is in FETCH; an in-flight Mem_Write or Reg_Write is dropped immediately.
REQ-031 In the first cycle after reset deasserts, I_Req=1 and a new fetch begins; no partial instruction resumes.

Configuration
REQ-032 With INSTRET_COUNT_EN defined, Instret is a 32-bit counter that increments on every Retire pulse, wraps from FFFFFFFF to 00000000, and resets to 0.
REQ-033 Without INSTRET_COUNT_EN, Instret is constant 0 and no counter logic is synthesized; all other behaviour is identical.

Verification
REQ-034 Ready inputs high, Opcode=0110011 -> States 0,1,2,4,0; Reg_Write high in cycle 4 only; ALU_Op=10; Retire=1 once.
REQ-035 Opcode=0000011, D_Ready low for 3 MEMORY cycles -> Mem_Read held for 4 cycles, then WRITEBACK with Mem_to_Reg=1 and Reg_Write=1; 8 cycles total.
REQ-036 Opcode=0100011, I_Ready low for 2 cycles -> I_Req held for 3 cycles; IR_Write/PC_Write pulse once; Mem_Write for 1 cycle; Reg_Write never 1.
REQ-037 Opcode=1111111 -> Illegal_Op pulse in DECODE, return to FETCH, Retire=0, no memory or register write.
REQ-038 Assert reset during a MEMORY cycle of SW -> Mem_Write=0 in the same cycle, State=0, Instret=0; fetch restarts after release.
REQ-039 INSTRET_COUNT_EN defined, counter preloaded to FFFFFFFF by forcing, one R-type retired -> Instret=00000000.
